// File: rtl/burst_pkg.sv
// Shared types and sizing helpers for the burst buffer / burst serializer pair.
package burst_pkg;

    // Sequencer states: post-reset settling, waiting for a burst, streaming a burst.
    typedef enum logic [1:0] {
        LATENCY,
        IDLE,
        SHIFT
    } state_t;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width of the latency counter and slot index; both must be able to hold
    // the larger of M and INITIAL_LATENCY.
    function automatic int cnt_width(input int m, input int lat);
        return $clog2(imax(m, lat) + 1);
    endfunction

endpackage

// File: rtl/burst_hold_reg.sv
// One-deep valid/ready holding register for a full burst. It accepts a new
// burst whenever it is empty, regardless of the clock enable, and empties when
// the sequencer copies the burst into its shift register.
module burst_hold_reg
    import burst_pkg::*;
#(
    parameter int M         = 5,
    parameter int PRECISION = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid_i,
    input  logic [M-1:0][PRECISION-1:0]     data_i,
    input  logic                            consume_i,
    output logic                            in_ready_o,
    output logic                            full_o,
    output logic [M-1:0][PRECISION-1:0]     data_o
);

    typedef logic [M-1:0][PRECISION-1:0] burst_t;

    logic   full_q, full_d;
    burst_t data_q, data_d;

    // Capture on handshake; consume only happens while full, so the two never coincide.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (in_valid_i && !full_q) begin
            full_d = 1'b1;
            data_d = data_i;
        end else if (consume_i) begin
            full_d = 1'b0;
        end
    end

    // Holding register state; reset discards any held burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign in_ready_o = !full_q;
    assign full_o     = full_q;
    assign data_o     = data_q;

endmodule

// File: rtl/burst_serializer.sv
// Streams M-word bursts out one PRECISION-bit word per clock-enable cycle,
// slot M-1 first. A holding register in front of the shift register lets the
// next burst wait so consecutive bursts leave with no gap.
module burst_serializer
    import burst_pkg::*;
#(
    parameter int INITIAL_LATENCY = 3,
    parameter int M               = 5,
    parameter int PRECISION       = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ce,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [M-1:0][PRECISION-1:0]     data_in,
    output logic [PRECISION-1:0]            data_out,
    output logic                            out_valid,
    output logic                            out_last,
    output logic                            underrun
);

    if (M < 2) begin : g_m_check
        $error("burst_serializer: M must be at least 2");
    end

    localparam int CW = cnt_width(M, INITIAL_LATENCY);
    localparam int SW = (M > 1) ? $clog2(M) : 1;

    localparam logic [CW-1:0] LAT_MAX  = CW'(INITIAL_LATENCY);
    localparam logic [CW-1:0] IDX_END  = CW'(M);
    localparam logic [CW-1:0] IDX_LAST = CW'(M - 1);
    localparam logic [SW-1:0] SLOT_TOP = SW'(M - 1);

    typedef logic [M-1:0][PRECISION-1:0] burst_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          idx_q, idx_d;
    burst_t                 sreg_q, sreg_d;
    logic [PRECISION-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic                   under_q, under_d;

    logic                   hold_full;
    burst_t                 hold_data;
    logic                   load;
    logic [SW-1:0]          sel;

    burst_hold_reg #(
        .M         (M),
        .PRECISION (PRECISION)
    ) u_hold (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (in_valid),
        .data_i     (data_in),
        .consume_i  (load),
        .in_ready_o (in_ready),
        .full_o     (hold_full),
        .data_o     (hold_data)
    );

    // A held burst moves into the shift register from IDLE, or straight after
    // the previous burst's slot 0 so the stream stays contiguous.
    assign load = ce && hold_full &&
                  ((state_q == IDLE) || ((state_q == SHIFT) && (idx_q == IDX_END)));

    // Slot to emit while streaming; only evaluated when idx < M.
    assign sel = SLOT_TOP - SW'(idx_q);

    // Next-state and output sequencing; nothing moves without ce.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sreg_d  = sreg_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        under_d = under_q;
        if (ce) begin
            under_d = 1'b0;
            if (load) begin
                data_d  = hold_data[M-1];
                valid_d = 1'b1;
                last_d  = 1'b0;
                sreg_d  = hold_data;
                idx_d   = CW'(1);
                state_d = SHIFT;
            end else begin
                case (state_q)
                    LATENCY: begin
                        if (cnt_q < LAT_MAX) begin
                            cnt_d = cnt_q + CW'(1);
                        end else begin
                            cnt_d   = '0;
                            state_d = IDLE;
                        end
                    end
                    IDLE: begin
                        valid_d = 1'b0;
                    end
                    SHIFT: begin
                        if (idx_q < IDX_END) begin
                            data_d  = sreg_q[sel];
                            valid_d = 1'b1;
                            last_d  = (idx_q == IDX_LAST);
                            idx_d   = idx_q + CW'(1);
                        end else begin
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            under_d = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    default: begin
                        state_d = LATENCY;
                    end
                endcase
            end
        end
    end

    // Sequencer registers; reset restarts the settling period and drops any burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LATENCY;
            cnt_q   <= '0;
            idx_q   <= '0;
            sreg_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            under_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sreg_q  <= sreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            under_q <= under_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign underrun  = under_q;

endmodule

// File: tb/tb_burst_serializer.sv
// Testbench for burst_serializer: directed scenarios plus random traffic,
// checked every cycle against a word-queue reference model.
module tb_burst_serializer;

    localparam int M               = 5;
    localparam int PRECISION       = 5;
    localparam int INITIAL_LATENCY = 3;

    typedef logic [M-1:0][PRECISION-1:0] burstT;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   ce = 1'b0;
    logic                   inValid = 1'b0;
    logic                   inReady;
    burstT                  dataIn = '0;
    logic [PRECISION-1:0]   dataOut;
    logic                   outValid;
    logic                   outLast;
    logic                   underrun;

    int    checkCount = 0;
    int    passCount  = 0;
    string phaseName  = "reset";

    // Reference model: a queue of words still to leave from the current burst,
    // a single held burst, and a count of settling edges left after reset.
    logic [PRECISION-1:0]   curQ[$];
    burstT                  mHold = '0;
    bit                     mFull = 1'b0;
    bit                     mAccepted = 1'b0;
    int                     latLeft = INITIAL_LATENCY + 1;
    logic [PRECISION-1:0]   expData = '0;
    bit                     expValid = 1'b0;
    bit                     expLast = 1'b0;
    bit                     expUnder = 1'b0;
    bit                     acc;
    bit                     wasLast;

    burstT                  pending[$];

    burst_serializer #(
        .INITIAL_LATENCY (INITIAL_LATENCY),
        .M               (M),
        .PRECISION       (PRECISION)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .data_in   (dataIn),
        .data_out  (dataOut),
        .out_valid (outValid),
        .out_last  (outLast),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    // Reference model update at each clock edge or reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            curQ.delete();
            mHold     = '0;
            mFull     = 1'b0;
            mAccepted = 1'b0;
            latLeft   = INITIAL_LATENCY + 1;
            expData   = '0;
            expValid  = 1'b0;
            expLast   = 1'b0;
            expUnder  = 1'b0;
        end else begin
            acc       = inValid && !mFull;
            mAccepted = acc;
            if (ce) begin
                wasLast  = expLast;
                expUnder = 1'b0;
                if (latLeft > 0) begin
                    latLeft--;
                end else begin
                    if (curQ.size() == 0 && mFull) begin
                        for (int s = M - 1; s >= 0; s--) curQ.push_back(mHold[s]);
                        mFull = 1'b0;
                    end
                    if (curQ.size() > 0) begin
                        expData  = curQ.pop_front();
                        expValid = 1'b1;
                        expLast  = (curQ.size() == 0);
                    end else begin
                        expValid = 1'b0;
                        expLast  = 1'b0;
                        expUnder = wasLast;
                    end
                end
            end
            if (acc) begin
                mHold = dataIn;
                mFull = 1'b1;
            end
        end
    end

    function automatic burstT mkBurst(input int base);
        burstT b;
        for (int s = 0; s < M; s++) b[s] = PRECISION'(base + s);
        return b;
    endfunction

    function automatic burstT randBurst();
        burstT b;
        for (int s = 0; s < M; s++) b[s] = PRECISION'($urandom);
        return b;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    endtask

    task automatic compareOutputs();
        checkOutput({phaseName, " data_out"},  32'(dataOut),  32'(expData));
        checkOutput({phaseName, " out_valid"}, 32'(outValid), 32'(expValid));
        checkOutput({phaseName, " out_last"},  32'(outLast),  32'(expLast));
        checkOutput({phaseName, " underrun"},  32'(underrun), 32'(expUnder));
        checkOutput({phaseName, " in_ready"},  32'(inReady),  32'(!mFull));
    endtask

    // Drive one cycle of inputs, let the edge happen, then check on the falling edge.
    task automatic applyStimulus(input logic ceV, input logic validV, input burstT d);
        ce      = ceV;
        inValid = validV;
        dataIn  = d;
        @(posedge clk);
        @(negedge clk);
        compareOutputs();
    endtask

    // Offer pending bursts; while the holder is full, present junk data with
    // in_valid still high so any capture under backpressure shows up.
    task automatic runTraffic(input int n, input int ceMode);
        for (int i = 0; i < n; i++) begin
            logic  ceV;
            bit    useFront;
            burstT d;
            case (ceMode)
                0:       ceV = 1'b1;
                1:       ceV = (i % 2 == 0);
                default: ceV = ($urandom_range(3) != 0);
            endcase
            useFront = (pending.size() > 0) && !mFull;
            d = useFront ? pending[0] : randBurst();
            applyStimulus(ceV, pending.size() > 0, d);
            if (mAccepted && useFront) void'(pending.pop_front());
        end
    endtask

    initial begin
        // Reset with the first burst already presented.
        phaseName = "reset";
        applyStimulus(1'b1, 1'b1, mkBurst(1));
        applyStimulus(1'b1, 1'b1, mkBurst(1));
        rst = 1'b0;

        // Basic stream 5..1 followed back-to-back by 10..6, with backpressure on the second.
        phaseName = "basic";
        pending.push_back(mkBurst(1));
        pending.push_back(mkBurst(6));
        runTraffic(22, 0);

        // Clock enable alternating every cycle.
        phaseName = "cegate";
        pending.push_back(mkBurst(11));
        pending.push_back(mkBurst(16));
        runTraffic(30, 1);

        // Single burst, underrun, then a late burst resuming from idle.
        phaseName = "underrun";
        pending.push_back(mkBurst(21));
        runTraffic(10, 0);
        runTraffic(3, 0);
        pending.push_back(mkBurst(26));
        runTraffic(10, 0);

        // Reset between edges in the middle of a burst.
        phaseName = "midreset";
        pending.push_back(mkBurst(2));
        pending.push_back(mkBurst(12));
        runTraffic(4, 0);
        #2 rst = 1'b1;
        #1 compareOutputs();
        checkOutput("midreset async out_valid", 32'(outValid), 32'd0);
        checkOutput("midreset async in_ready", 32'(inReady), 32'd1);
        pending.delete();
        @(negedge clk);
        compareOutputs();
        rst = 1'b0;
        pending.push_back(mkBurst(7));
        runTraffic(15, 0);

        // Random traffic with random clock enable.
        phaseName = "random";
        for (int k = 0; k < 40; k++) begin
            if (pending.size() < 2 && $urandom_range(1) == 1) pending.push_back(randBurst());
            runTraffic(10, 2);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
